// File: rtl/tinst_pkg.sv
// Shared types and default widths for the test_inst operand driver.
package tinst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_IN_WIDTH  = 4;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int M_WIDTH       = 3;
  localparam int N_WIDTH       = 4;

endpackage

// File: rtl/tinst_rsp_fifo.sv
// Result FIFO for the test_inst driver; the head reads as zero while the FIFO is empty.
module tinst_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // The issue credit makes these unreachable; a hit means the credit is broken.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule

// File: rtl/test_inst_drv.sv
// Initiator-side driver: issues operands to test_inst, collects c after a
// fixed latency and returns results in order through a credit-limited FIFO.
module test_inst_drv
  import tinst_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int LAT       = 2,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IN_WIDTH-1:0]  cmd_a,
  input  logic [IN_WIDTH-1:0]  cmd_b,
  input  logic [M_WIDTH-1:0]   cmd_m,
  input  logic [N_WIDTH-1:0]   cmd_n,
  output logic [IN_WIDTH-1:0]  a,
  output logic [IN_WIDTH-1:0]  b,
  output logic [M_WIDTH-1:0]   m,
  output logic [N_WIDTH-1:0]   n,
  input  logic [OUT_WIDTH-1:0] c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OUT_WIDTH-1:0] rsp_c,
  output logic                 busy,
  output logic [15:0]          issue_cnt
);

  state_t state_q;
  state_t state_d;

  logic [LAT-1:0]          pipe_q;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [3:0]              inflight;
  logic [7:0]              outstanding;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + 4'(pipe_q[i]);
    end
  end

  // Credit covers both the latency pipe and the FIFO, so a push never meets a full FIFO.
  assign outstanding = 8'(inflight) + 8'(fifo_count);
  assign cmd_ready   = (state_q == RUN) && (outstanding < 8'(DEPTH));
  assign accept      = cmd_valid && cmd_ready;
  assign push        = pipe_q[LAT-1];
  assign rsp_valid   = !fifo_empty;
  assign pop         = rsp_valid && rsp_ready;
  assign busy        = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)            state_d = RUN;
        else if (pipe_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pipe_q    <= '0;
      a         <= '0;
      b         <= '0;
      m         <= '0;
      n         <= '0;
      issue_cnt <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= (pipe_q << 1) | LAT'(accept);
      if (accept) begin
        a <= cmd_a;
        b <= cmd_b;
        m <= cmd_m;
        n <= cmd_n;
        if (issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

  tinst_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (c),
    .pop   (pop),
    .rdata (rsp_c),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_test_inst_drv.sv
// Bench for test_inst_drv: directed scenarios plus random traffic against a
// transaction-level scoreboard and a stand-in model of test_inst.
module tb_test_inst_drv;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_a = '0;
  logic [3:0]  cmd_b = '0;
  logic [2:0]  cmd_m = '0;
  logic [3:0]  cmd_n = '0;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [2:0]  m;
  logic [3:0]  n;
  logic [7:0]  c = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_c;
  logic        busy;
  logic [15:0] issue_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         accepted = 0;
  int         popped = 0;
  logic       en_prev = 1'b0;

  test_inst_drv #(
    .IN_WIDTH  (4),
    .OUT_WIDTH (8),
    .LAT       (LAT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_m     (cmd_m),
    .cmd_n     (cmd_n),
    .a         (a),
    .b         (b),
    .m         (m),
    .n         (n),
    .c         (c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_c(input logic [3:0] fa, input logic [3:0] fb,
                                       input logic [2:0] fm, input logic [3:0] fn);
    return ({4'b0, fa} * {4'b0, fb}) ^ {fn, 1'b0, fm};
  endfunction

  // Stand-in for test_inst: c follows the driven operands one register later.
  always @(posedge clk) c <= ref_c(a, b, m, n);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshake is recorded just before the edge that completes it.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      accepted = 0;
      popped   = 0;
      en_prev  = 1'b0;
    end else begin
      chk("issue_cnt", 64'(issue_cnt), 64'(accepted));
      chk("cmd_ready", 64'(cmd_ready),
          64'(en_prev && ((accepted - popped) < DEPTH)));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_spurious", 64'(rsp_valid), 64'(0));
        end else begin
          chk("rsp_c_order", 64'(rsp_c), 64'(exp_q.pop_front()));
          popped++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(ref_c(cmd_a, cmd_b, cmd_m, cmd_n));
        accepted++;
      end
      en_prev = enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cmd();
    cmd_a = 4'($urandom);
    cmd_b = 4'($urandom);
    cmd_m = 3'($urandom);
    cmd_n = 4'($urandom);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Holds cmd_valid for the given cycles and returns how many were accepted.
  task automatic push_cmds(input int cycles, output int n_acc);
    logic hs;
    n_acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      hs = cmd_ready;
      tick();
      if (hs) begin
        n_acc++;
        rand_cmd();
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n_acc;
    int n_stale;

    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ctl", 64'({cmd_ready, rsp_valid, busy}), 64'(0));
      chk("idle_out", 64'({a, b, m, n, rsp_c, issue_cnt}), 64'(0));
    end

    enable = 1'b1;
    tick();
    chk("run_ready", 64'(cmd_ready), 64'(1));
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_m = 3'd2; cmd_n = 4'd9;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("ops_single", 64'({a, b, m, n}), 64'({4'd3, 4'd5, 3'd2, 4'd9}));
    chk("lat_t1", 64'(rsp_valid), 64'(0));
    tick();
    chk("lat_t2", 64'(rsp_valid), 64'(0));
    tick();
    chk("lat_t3", 64'(rsp_valid), 64'(1));
    chk("rsp_single", 64'(rsp_c), 64'(ref_c(4'd3, 4'd5, 3'd2, 4'd9)));
    chk("ops_hold", 64'({a, b, m, n}), 64'({4'd3, 4'd5, 3'd2, 4'd9}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single_popped", 64'(rsp_valid), 64'(0));

    rand_cmd();
    push_cmds(10, n_acc);
    chk("bp_accepts", 64'(n_acc), 64'(DEPTH));
    chk("bp_ready_low", 64'(cmd_ready), 64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    push_cmds(8, n_acc);
    chk("bp_one_more", 64'(n_acc), 64'(1));
    rsp_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drained", 64'(rsp_valid), 64'(0));

    do_reset();
    enable = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rand_cmd();
    push_cmds(100, n_acc);
    chk("stream_accepts", 64'(n_acc), 64'(100));
    repeat (6) tick();
    chk("stream_issue", 64'(issue_cnt), 64'(100));
    chk("stream_pops", 64'(popped), 64'(100));

    rsp_ready = 1'b0;
    rand_cmd();
    push_cmds(2, n_acc);
    enable = 1'b0;
    chk("drain_pre", 64'(n_acc), 64'(2));
    tick();
    chk("drain_ready", 64'(cmd_ready), 64'(0));
    chk("drain_busy", 64'(busy), 64'(1));
    repeat (4) tick();
    chk("drain_fifo", 64'(rsp_valid), 64'(1));
    chk("drain_busy_fifo", 64'(busy), 64'(1));
    rsp_ready = 1'b1;
    repeat (2) tick();
    rsp_ready = 1'b0;
    chk("drain_idle", 64'({busy, rsp_valid}), 64'(0));
    chk("drain_pops", 64'(popped), 64'(102));

    enable = 1'b1;
    tick();
    rand_cmd();
    push_cmds(3, n_acc);
    chk("mid_accepts", 64'(n_acc), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_issue", 64'(issue_cnt), 64'(0));
    chk("rst_ops", 64'({a, b, m, n, cmd_ready, busy}), 64'(0));
    repeat (2) tick();
    enable = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    n_stale = 0;
    repeat (10) begin
      tick();
      if (rsp_valid) n_stale++;
    end
    chk("rst_no_stale", 64'(n_stale), 64'(0));

    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_cmd();
      tick();
    end
    enable    = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) tick();
    chk("final_idle", 64'({busy, rsp_valid}), 64'(0));
    chk("final_issue", 64'(issue_cnt), 64'(accepted));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
